// File: rtl/demux_pkg.sv
// Shared constants for the 1:8 serial-to-parallel demux: frame geometry,
// FSM state encoding and the slot mapping helper.
package demux_pkg;

   localparam int FRAME_W = 8;
   localparam int SEL_W   = 3;

   localparam logic [0:0] IDLE    = 1'b0;
   localparam logic [0:0] COLLECT = 1'b1;

   // For an 8-slot frame, 7-i is the bitwise complement of i.
   function automatic logic [SEL_W-1:0] slot(input logic [SEL_W-1:0] idx,
                                             input bit msb_first);
      return msb_first ? ~idx : idx;
   endfunction

endpackage

// File: rtl/decoder_3x8.sv
// 3-to-8 one-hot decoder with enable.
// It produces the per-slot write strobes for the shadow register.
module decoder_3x8
   import demux_pkg::*;
(
   input  logic               en_i,
   input  logic [SEL_W-1:0]   idx_i,
   output logic [FRAME_W-1:0] onehot_o
);

   always_comb begin
      // NOTE: default first so every path assigns the output; otherwise a latch is inferred.
      onehot_o = '0;
      if (en_i) begin
         onehot_o[idx_i] = 1'b1;
      end
   end

endmodule

// File: rtl/demux_1x8_sipo.sv
// Rebuilds 8-bit frames from the serial stream of a scanned 8:1 mux.
// It publishes each completed frame on y with a one-cycle done pulse.
module demux_1x8_sipo
   import demux_pkg::*;
#(
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               din,
   input  logic               din_valid,
   input  logic               clr,
   output logic [SEL_W-1:0]   sel,
   output logic [FRAME_W-1:0] y,
   output logic               done,
   output logic               busy
);

   logic [0:0]         state_q,  state_d;
   logic [SEL_W-1:0]   sel_q,    sel_d;
   logic [FRAME_W-1:0] shadow_q, shadow_d;
   logic [FRAME_W-1:0] y_q,      y_d;
   logic               done_q,   done_d;
   logic               busy_q,   busy_d;

   logic [FRAME_W-1:0] wr_en;
   logic [FRAME_W-1:0] merged;
   logic               last_bit;

   decoder_3x8 u_slot_dec (
      .en_i     (din_valid & ~clr),
      .idx_i    (slot(sel_q, MSB_FIRST)),
      .onehot_o (wr_en)
   );

   // The shadow contents with the current bit placed in its slot.
   // On the 8th bit this is the complete frame.
   assign merged   = (shadow_q & ~wr_en) | ({FRAME_W{din}} & wr_en);
   assign last_bit = (state_q == COLLECT) && (sel_q == SEL_W'(FRAME_W - 1));

   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      shadow_d = shadow_q;
      y_d      = y_q;
      done_d   = 1'b0;

      if (clr) begin
         state_d  = IDLE;
         sel_d    = '0;
         shadow_d = '0;
      end else if (din_valid) begin
         if (last_bit) begin
            y_d      = merged;
            done_d   = 1'b1;
            state_d  = IDLE;
            sel_d    = '0;
            shadow_d = '0;
         end else begin
            shadow_d = merged;
            sel_d    = sel_q + 1'b1;
            state_d  = COLLECT;
         end
      end

      busy_d = (state_d == COLLECT);
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments make every flop sample pre-edge values.
      if (rst) begin
         state_q  <= IDLE;
         sel_q    <= '0;
         shadow_q <= '0;
         y_q      <= '0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         shadow_q <= shadow_d;
         y_q      <= y_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
      end
   end

   assign sel  = sel_q;
   assign y    = y_q;
   assign done = done_q;
   assign busy = busy_q;

endmodule

// File: tb/tb_demux_1x8_sipo.sv
// Bench for demux_1x8_sipo: an LSB-first and an MSB-first instance share stimulus.
// A frame-level model is compared against both every cycle.
module tb_demux_1x8_sipo;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic din = 1'b0;
   logic din_valid = 1'b0;
   logic clr = 1'b0;

   logic [2:0] sel0, sel1;
   logic [7:0] y0, y1;
   logic       done0, done1, busy0, busy1;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int done_cyc[$];
   logic [7:0] done_y[$];

   demux_1x8_sipo #(.MSB_FIRST(1'b0)) dut_lsb (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clr(clr),
      .sel(sel0), .y(y0), .done(done0), .busy(busy0)
   );

   demux_1x8_sipo #(.MSB_FIRST(1'b1)) dut_msb (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clr(clr),
      .sel(sel1), .y(y1), .done(done1), .busy(busy1)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] rev8(input logic [7:0] v);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = v[7-i];
      return r;
   endfunction

   // Frame model: count accepted bits and keep them in arrival order.
   // Instance 1 reports the frame bit-reversed.
   int         m_cnt[2] = '{0, 0};
   logic [7:0] m_acc[2] = '{8'h00, 8'h00};
   logic [7:0] m_y[2]   = '{8'h00, 8'h00};
   logic       m_done[2] = '{1'b0, 1'b0};

   always @(posedge clk) begin
      for (int m = 0; m < 2; m++) begin
         if (rst) begin
            m_cnt[m]  <= 0;
            m_y[m]    <= 8'h00;
            m_done[m] <= 1'b0;
         end else begin
            m_done[m] <= 1'b0;
            if (clr) begin
               m_cnt[m] <= 0;
            end else if (din_valid) begin
               m_acc[m][m_cnt[m]] <= din;
               if (m_cnt[m] == 7) begin
                  m_y[m]    <= (m == 1) ? rev8({din, m_acc[m][6:0]}) : {din, m_acc[m][6:0]};
                  m_done[m] <= 1'b1;
                  m_cnt[m]  <= 0;
               end else begin
                  m_cnt[m] <= m_cnt[m] + 1;
               end
            end
         end
      end
   end

   always @(posedge clk) begin
      #2;
      cyc++;
      check("sel0",  {29'd0, sel0}, m_cnt[0]);
      check("y0",    {24'd0, y0},   {24'd0, m_y[0]});
      check("done0", {31'd0, done0}, {31'd0, m_done[0]});
      check("busy0", {31'd0, busy0}, (m_cnt[0] != 0) ? 32'd1 : 32'd0);
      check("sel1",  {29'd0, sel1}, m_cnt[1]);
      check("y1",    {24'd0, y1},   {24'd0, m_y[1]});
      check("done1", {31'd0, done1}, {31'd0, m_done[1]});
      check("busy1", {31'd0, busy1}, (m_cnt[1] != 0) ? 32'd1 : 32'd0);
      if (done0) begin
         done_cyc.push_back(cyc);
         done_y.push_back(y0);
      end
   end

   // Sends the first n bits of v, bit 0 first.
   // With gapped=1 there are 1-3 idle cycles between bits.
   // din_valid is left high after the last bit.
   task automatic send_bits(input logic [7:0] v, input int n, input bit gapped);
      for (int i = 0; i < n; i++) begin
         din       = v[i];
         din_valid = 1'b1;
         @(negedge clk);
         if (gapped && i < n - 1) begin
            din_valid = 1'b0;
            check("busy_mid_frame", {31'd0, busy0}, 32'd1);
            repeat (1 + (i % 3)) @(negedge clk);
         end
      end
   endtask

   initial begin
      int nd;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_y",    {24'd0, y0},    32'h00);
      check("rst_sel",  {29'd0, sel0},  32'd0);
      check("rst_done", {31'd0, done0}, 32'd0);
      check("rst_busy", {31'd0, busy0}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Back-to-back frame 0xA7.
      send_bits(8'hA7, 8, 1'b0);
      check("a_done",  {31'd0, done0}, 32'd1);
      check("a_y_lsb", {24'd0, y0}, 32'hA7);
      check("a_y_msb", {24'd0, y1}, 32'hE5);
      din_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("a_sel_after", {29'd0, sel0}, 32'd0);
      check("a_pulses", done_cyc.size(), 32'd1);

      // The same frame with idle gaps between bits.
      send_bits(8'hA7, 8, 1'b1);
      din_valid = 1'b0;
      check("b_y", {24'd0, y0}, 32'hA7);
      repeat (2) @(negedge clk);
      check("b_pulses", done_cyc.size(), 32'd2);

      // Abort after four bits; clr wins over a concurrent valid bit.
      send_bits(8'hFF, 4, 1'b0);
      clr = 1'b1;
      din = 1'b1;
      @(negedge clk);
      clr       = 1'b0;
      din_valid = 1'b0;
      check("c_sel_clr",  {29'd0, sel0},  32'd0);
      check("c_busy_clr", {31'd0, busy0}, 32'd0);
      check("c_y_held",   {24'd0, y0},    32'hA7);
      @(negedge clk);
      check("c_no_done", done_cyc.size(), 32'd2);
      send_bits(8'h3C, 8, 1'b0);
      din_valid = 1'b0;
      check("c_y", {24'd0, y0}, 32'h3C);
      check("c_pulses", done_cyc.size(), 32'd3);
      @(negedge clk);

      // Two back-to-back frames with din_valid held high.
      nd = done_cyc.size();
      send_bits(8'hA7, 8, 1'b0);
      send_bits(8'h5A, 8, 1'b0);
      din_valid = 1'b0;
      @(negedge clk);
      check("d_pulses", done_cyc.size(), nd + 2);
      if (done_cyc.size() >= nd + 2) begin
         check("d_spacing", done_cyc[nd+1] - done_cyc[nd], 32'd8);
         check("d_y1", {24'd0, done_y[nd]},   32'hA7);
         check("d_y2", {24'd0, done_y[nd+1]}, 32'h5A);
      end

      // MSB-first frame, then a reset in the middle of a frame.
      send_bits(8'hE5, 8, 1'b0);
      check("e_y_msb",    {24'd0, y1},    32'hA7);
      check("e_done_msb", {31'd0, done1}, 32'd1);
      din_valid = 1'b0;
      @(negedge clk);
      send_bits(8'hFF, 5, 1'b0);
      din_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("e_rst_y",    {24'd0, y1},    32'h00);
      check("e_rst_done", {31'd0, done1}, 32'd0);
      check("e_rst_busy", {31'd0, busy1}, 32'd0);
      @(negedge clk);
      check("e_rst_no_done", {31'd0, done1}, 32'd0);
      check("e_rst_sel",     {29'd0, sel1},  32'd0);
      repeat (2) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
